// File: rtl/ram_writer.sv
// AXI3 write-burst master: drains a 512x64 BRAM buffer into DRAM as 128-byte INCR bursts.
// AW issues independently of W; done (READY) only after every B response has returned.
module ram_writer (
    input  logic        ACLK,
    input  logic        ARESETN,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [3:0]  M_AXI_AWLEN,
    output logic [1:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic [63:0] M_AXI_WDATA,
    output logic [7:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    output logic        M_AXI_WLAST,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic        VALID,
    output logic        READY,
    input  logic [31:0] START_ADDR,
    input  logic [31:0] NBYTES,
    output logic        ERROR,
    output logic [8:0]  RAM_ADDR,
    output logic        RAM_RE,
    input  logic [63:0] RAM_DO,
    input  logic [12:0] BYTES_AVAIL,
    output logic        READ_BYTES
);

    // state    | meaning
    // AW_IDLE  | no address bursts left to issue
    // AW_ISSUE | AWVALID high, waiting for AWREADY
    typedef enum logic {AW_IDLE, AW_ISSUE} aw_state_t;

    aw_state_t   r_aw_state, w_aw_next;
    logic [31:0] r_awaddr;
    logic [24:0] r_aw_left;
    logic [24:0] r_b_left;
    logic [28:0] r_words_left;
    logic [8:0]  r_ram_addr;
    logic        r_inflight;
    logic [63:0] r_fifo0, r_fifo1;
    logic [1:0]  r_count;
    logic [3:0]  r_beat;
    logic        r_error;

    logic [24:0] w_nbursts;
    logic        w_ready, w_accept, w_start;
    logic        w_aw_hs, w_b_hs, w_pop, w_push, w_re;
    logic [2:0]  w_slots_used;
    logic        w_unused;

    assign w_nbursts = NBYTES[31:7];
    assign w_unused  = ^NBYTES[6:0];

    assign w_ready  = (r_aw_state == AW_IDLE) && (r_words_left == 29'd0) && (r_count == 2'd0)
                      && !r_inflight && (r_b_left == 25'd0);
    assign w_accept = VALID && w_ready;
    assign w_start  = w_accept && (w_nbursts != 25'd0);

    assign w_aw_hs = (r_aw_state == AW_ISSUE) && M_AXI_AWREADY;
    assign w_b_hs  = (r_b_left != 25'd0) && M_AXI_BVALID;
    assign w_pop   = (r_count != 2'd0) && M_AXI_WREADY;
    assign w_push  = r_inflight;

    // A beat leaving this cycle frees its slot in time for the fetch issued now, keeping 1 beat/cycle.
    assign w_slots_used = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_re = (r_words_left != 29'd0) && (BYTES_AVAIL >= 13'd8) && (w_slots_used <= 3'd1);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_aw_state <= AW_IDLE;
        else          r_aw_state <= w_aw_next;
    end

    always_comb begin
        w_aw_next     = r_aw_state;
        M_AXI_AWVALID = 1'b0;
        case (r_aw_state)
            AW_IDLE: begin
                if (w_start) w_aw_next = AW_ISSUE;
            end
            AW_ISSUE: begin
                M_AXI_AWVALID = 1'b1;
                if (w_aw_hs && (r_aw_left == 25'd1)) w_aw_next = AW_IDLE;
            end
            default: w_aw_next = AW_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_awaddr     <= 32'd0;
            r_aw_left    <= 25'd0;
            r_b_left     <= 25'd0;
            r_words_left <= 29'd0;
            r_ram_addr   <= 9'd0;
            r_inflight   <= 1'b0;
            r_fifo0      <= 64'd0;
            r_fifo1      <= 64'd0;
            r_count      <= 2'd0;
            r_beat       <= 4'd0;
            r_error      <= 1'b0;
        end else begin
            if (w_start) begin
                r_awaddr     <= START_ADDR;
                r_aw_left    <= w_nbursts;
                r_b_left     <= w_nbursts;
                r_words_left <= {w_nbursts, 4'b0000};
            end else begin
                if (w_aw_hs) begin
                    r_awaddr  <= r_awaddr + 32'd128;
                    r_aw_left <= r_aw_left - 25'd1;
                end
                if (w_b_hs) r_b_left <= r_b_left - 25'd1;
                if (w_re)   r_words_left <= r_words_left - 29'd1;
            end

            if (w_accept)  r_ram_addr <= 9'd0;
            else if (w_re) r_ram_addr <= r_ram_addr + 9'd1;

            if (w_accept)                                r_error <= 1'b0;
            else if (w_b_hs && (M_AXI_BRESP != 2'b00))   r_error <= 1'b1;

            r_inflight <= w_re;
            if (w_pop) r_beat <= r_beat + 4'd1;

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_fifo0 <= RAM_DO;
                    else                 r_fifo1 <= RAM_DO;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_fifo0 <= r_fifo1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_fifo0 <= RAM_DO;
                    end else begin
                        r_fifo0 <= r_fifo1;
                        r_fifo1 <= RAM_DO;
                    end
                end
                default: ;
            endcase
        end
    end

    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = 4'b1111;
    assign M_AXI_AWSIZE  = 2'b11;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = r_fifo0;
    assign M_AXI_WSTRB   = 8'hFF;
    assign M_AXI_WVALID  = (r_count != 2'd0);
    assign M_AXI_WLAST   = (r_beat == 4'd15) && (r_count != 2'd0);
    assign M_AXI_BREADY  = (r_b_left != 25'd0);
    assign READY         = w_ready;
    assign ERROR         = r_error;
    assign RAM_ADDR      = r_ram_addr;
    assign RAM_RE        = w_re;
    assign READ_BYTES    = w_re;

endmodule

// File: tb/tb_ram_writer.sv
// Bench for ram_writer: BRAM + AXI slave model, per-job scoreboard of AW/W/B traffic
// against addresses start+128*i and data RAM[i mod 512].
module tb_ram_writer;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [3:0]  M_AXI_AWLEN;
    logic [1:0]  M_AXI_AWSIZE, M_AXI_AWBURST;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic        VALID, READY, ERROR;
    logic [31:0] START_ADDR, NBYTES;
    logic [8:0]  RAM_ADDR;
    logic        RAM_RE, READ_BYTES;
    logic [63:0] RAM_DO;
    logic [12:0] BYTES_AVAIL;

    always #5 ACLK = ~ACLK;

    ram_writer dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .VALID(VALID), .READY(READY), .START_ADDR(START_ADDR), .NBYTES(NBYTES), .ERROR(ERROR),
        .RAM_ADDR(RAM_ADDR), .RAM_RE(RAM_RE), .RAM_DO(RAM_DO),
        .BYTES_AVAIL(BYTES_AVAIL), .READ_BYTES(READ_BYTES)
    );

    logic [63:0] mem [512];
    int checks = 0;
    int errors = 0;

    int aw_cnt, w_cnt, wl_cnt, b_cnt, re_cnt, stab_err, addr_err;
    logic [31:0] aw_log [1024];
    logic [63:0] w_log  [1024];
    logic        wl_log [1024];
    logic [12:0] produced, consumed;
    bit          mon_clr, wr_rand;
    int          err_at;
    logic        hold_prev, hold_last;
    logic [63:0] hold_data;

    assign BYTES_AVAIL = produced - consumed;

    always @(posedge ACLK) if (RAM_RE) RAM_DO <= mem[RAM_ADDR];

    // Monitor: logs every handshake; cleared by reset or between jobs.
    always @(posedge ACLK) begin
        if (!ARESETN || mon_clr) begin
            aw_cnt <= 0; w_cnt <= 0; wl_cnt <= 0; b_cnt <= 0; re_cnt <= 0;
            stab_err <= 0; addr_err <= 0; consumed <= 13'd0; hold_prev <= 1'b0;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY && aw_cnt < 1024) begin
                aw_log[aw_cnt] <= M_AXI_AWADDR;
                aw_cnt <= aw_cnt + 1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY && w_cnt < 1024) begin
                w_log[w_cnt]  <= M_AXI_WDATA;
                wl_log[w_cnt] <= M_AXI_WLAST;
                w_cnt <= w_cnt + 1;
                if (M_AXI_WLAST) wl_cnt <= wl_cnt + 1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_cnt <= b_cnt + 1;
            if (READ_BYTES) begin
                consumed <= consumed + 13'd8;
                re_cnt   <= re_cnt + 1;
                if (RAM_ADDR != 9'(re_cnt)) addr_err <= addr_err + 1;
            end
            if (hold_prev && !(M_AXI_WVALID && M_AXI_WDATA == hold_data && M_AXI_WLAST == hold_last))
                stab_err <= stab_err + 1;
            hold_prev <= M_AXI_WVALID && !M_AXI_WREADY;
            hold_data <= M_AXI_WDATA;
            hold_last <= M_AXI_WLAST;
        end
    end

    // Slave: B returned once both the address and the last data beat of a burst have been seen.
    always @(negedge ACLK) begin
        M_AXI_AWREADY = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        M_AXI_WREADY  = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        M_AXI_BVALID  = ARESETN && !mon_clr && (wl_cnt > b_cnt) && (aw_cnt > b_cnt);
        M_AXI_BRESP   = (M_AXI_BVALID && b_cnt == err_at) ? 2'b10 : 2'b00;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] nbytes, input logic [31:0] start, input int avail,
                             input bit wrand, input int errat);
        @(negedge ACLK) mon_clr = 1'b1;
        @(negedge ACLK) mon_clr = 1'b0;
        produced = 13'(avail);
        wr_rand  = wrand;
        err_at   = errat;
        chk("ready_idle", READY, 1);
        VALID = 1'b1; NBYTES = nbytes; START_ADDR = start;
        @(negedge ACLK);
        VALID = 1'b0; NBYTES = $urandom; START_ADDR = $urandom;
        chk("error_cleared_on_accept", ERROR, 0);
        if (nbytes[31:7] != 25'd0) begin
            chk("ready_low_after_accept", READY, 0);
            chk("awvalid_after_accept", M_AXI_AWVALID, 1);
        end else begin
            chk("ready_stays_high", READY, 1);
            chk("no_awvalid_empty_job", M_AXI_AWVALID, 0);
        end
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (READY) break;
            @(negedge ACLK);
        end
        chk("ready_timeout", READY, 1);
    endtask

    task automatic check_job(input int nb, input logic [31:0] start, input bit exp_err);
        int bad_a, bad_d, bad_l;
        bad_a = 0; bad_d = 0; bad_l = 0;
        chk("aw_count", aw_cnt, nb);
        for (int i = 0; i < aw_cnt && i < 1024; i++)
            if (aw_log[i] !== start + 32'(128 * i)) bad_a++;
        chk("aw_addr_bad", bad_a, 0);
        chk("w_count", w_cnt, nb * 16);
        for (int i = 0; i < w_cnt && i < 1024; i++) begin
            if (w_log[i] !== mem[i % 512]) bad_d++;
            if (wl_log[i] !== ((i % 16) == 15)) bad_l++;
        end
        chk("wdata_bad", bad_d, 0);
        chk("wlast_bad", bad_l, 0);
        chk("b_count", b_cnt, nb);
        chk("read_pulses", re_cnt, nb * 16);
        chk("wdata_unstable", stab_err, 0);
        chk("ram_addr_seq", addr_err, 0);
        chk("error_flag", ERROR, exp_err);
    endtask

    typedef struct {
        logic [31:0] nbytes;
        logic [31:0] start;
        int          avail;
        bit          wrand;
        int          err_at;
        int          exp_nb;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n, nb, ea;
        logic [31:0] nbytes, start;
        vecs[0] = '{32'd256,           32'h0000_1000, 4096, 1'b0, -1,  2, 1'b0};
        vecs[1] = '{32'd512,           32'h2000_0000, 4096, 1'b1, -1,  4, 1'b0};
        vecs[2] = '{32'd384 | 32'h55,  32'h0000_8000, 4096, 1'b0,  1,  3, 1'b1};
        vecs[3] = '{32'h7F,            32'h0000_0000, 4096, 1'b0, -1,  0, 1'b0};
        vecs[4] = '{32'd128,           32'hFFFF_FF80, 4096, 1'b1, -1,  1, 1'b0};
        vecs[5] = '{32'd5120,          32'h0010_0000, 8000, 1'b1, 17, 40, 1'b1};

        for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
        ARESETN = 1'b0; VALID = 1'b0; NBYTES = 32'd0; START_ADDR = 32'd0;
        produced = 13'd0; mon_clr = 1'b0; wr_rand = 1'b0; err_at = -1;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        chk("rst_ready", READY, 1);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_wlast", M_AXI_WLAST, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_ram_re", RAM_RE, 0);
        chk("rst_ram_addr", RAM_ADDR, 0);
        chk("rst_awaddr", M_AXI_AWADDR, 0);
        chk("rst_error", ERROR, 0);
        chk("awlen", M_AXI_AWLEN, 4'hF);
        chk("awsize", M_AXI_AWSIZE, 2'b11);
        chk("awburst", M_AXI_AWBURST, 2'b01);
        chk("wstrb", M_AXI_WSTRB, 8'hFF);

        for (int v = 0; v < 6; v++) begin
            start_job(vecs[v].nbytes, vecs[v].start, vecs[v].avail, vecs[v].wrand, vecs[v].err_at);
            if (vecs[v].exp_nb != 0) wait_ready(20000);
            else repeat (10) @(negedge ACLK);
            check_job(vecs[v].exp_nb, vecs[v].start, vecs[v].exp_err);
        end

        for (int k = 0; k < 6; k++) begin
            nb     = $urandom_range(1, 8);
            nbytes = (32'(nb) << 7) | ($urandom & 32'h7F);
            start  = $urandom & ~32'h7F;
            ea     = $urandom_range(0, nb);
            start_job(nbytes, start, 4096, 1'b1, ea);
            wait_ready(20000);
            check_job(nb, start, ea < nb);
        end

        // Producer starved: AW goes out, no fetch or W until bytes arrive.
        start_job(32'd128, 32'h0000_3000, 0, 1'b0, -1);
        repeat (20) @(negedge ACLK);
        chk("starve_no_re", re_cnt, 0);
        chk("starve_no_w", w_cnt, 0);
        chk("starve_aw_sent", aw_cnt, 1);
        produced = 13'd128;
        wait_ready(2000);
        check_job(1, 32'h0000_3000, 1'b0);
        chk("starve_avail_drained", BYTES_AVAIL, 0);

        // Reset in the middle of burst 2, then a fresh job must complete.
        start_job(32'd256, 32'h0000_5000, 4096, 1'b0, -1);
        n = 0;
        while (w_cnt < 23 && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        chk("midjob_beats_reached", w_cnt >= 23, 1);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("midrst_awvalid", M_AXI_AWVALID, 0);
        chk("midrst_wvalid", M_AXI_WVALID, 0);
        chk("midrst_wlast", M_AXI_WLAST, 0);
        chk("midrst_bready", M_AXI_BREADY, 0);
        chk("midrst_ready", READY, 1);
        chk("midrst_ram_addr", RAM_ADDR, 0);
        chk("midrst_ram_re", RAM_RE, 0);
        ARESETN = 1'b1;
        start_job(32'd128, 32'h0000_6000, 4096, 1'b0, -1);
        wait_ready(2000);
        check_job(1, 32'h0000_6000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
